// File: rtl/led_shift_pkg.sv
// Shared types and defaults for the LED serial output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   STATE_W      width of the state encoding
//   state_t      IDLE -> SHIFT_LO -> SHIFT_HI (per bit) -> LATCH -> IDLE
//   DEF_WIDTH    default frame width / led bus width
//   DEF_CLK_DIV  default CLK cycles per sclk half-period and per latch pulse
package led_shift_pkg;

  localparam int STATE_W     = 2;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/led_shift_out_if.sv
// Bundle between the upstream counter/LED block, this stage and the 595 pins.
// Latency: n/a (wires only).
// Backpressure: none; force_req is a one-cycle request, busy/done report status.
//   led_in     parallel LED value (upstream -> stage)
//   force_req  one-cycle resend request (upstream -> stage)
//   busy/done  frame status (stage -> upstream)
//   sclk/sdata/latch  serial pins to the external shift register
interface led_shift_out_if import led_shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] led_in;
  logic             force_req;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             sdata;
  logic             latch;

  modport master (
    output led_in, force_req,
    input  busy, done, sclk, sdata, latch
  );

  modport slave (
    input  led_in, force_req,
    output busy, done, sclk, sdata, latch
  );
endinterface

// File: rtl/led_tick_div.sv
// Phase timer: down-counter marking the last cycle of each CLK_DIV-cycle phase.
// Latency: tick is high on the CLK_DIV-th cycle after restart drops.
// Backpressure: none; restart holds the counter at its reload value.
//   CLK      in  system clock
//   RST_N    in  async active-low reset
//   restart  in  hold/reload the counter so the next phase starts fresh
//   tick     out high on the final cycle of the current phase
module led_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  output logic tick
);

  localparam int            CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Auto-reloads on tick so consecutive phases need no explicit restart.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= RELOAD;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/led_shift_out.sv
// Serialises the led byte to a 595-style shift register when it changes, on force, or once after reset.
// Latency: frame starts the cycle after the start condition; frame = (2*WIDTH+1)*CLK_DIV cycles, then done.
// Backpressure: led_in is sampled only in IDLE; force_req while busy is remembered for one extra frame.
//   CLK    in   system clock
//   RST_N  in   async active-low reset; abandons any frame in flight
//   bus    slave modport: led_in/force_req in, busy/done/sclk/sdata/latch out (all registered)
module led_shift_out import led_shift_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  led_shift_out_if.slave bus
);

  localparam int BW = $clog2(WIDTH);

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [WIDTH-1:0]  last_sent;
  logic [WIDTH-1:0]  shifted;
  logic [BW-1:0]     bit_cnt;
  logic              init;
  logic              pending;
  logic              start;
  logic              tick;
  logic              busy_q;
  logic              done_q;
  logic              sclk_q;
  logic              sdata_q;
  logic              latch_q;

  function automatic logic pick(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // The divider idles at its reload value, so every phase lasts exactly CLK_DIV cycles.
  led_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .restart (state == IDLE),
    .tick    (tick)
  );

  assign start   = init | pending | bus.force_req | (bus.led_in != last_sent);
  assign shifted = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      shift_reg <= '0;
      last_sent <= '0;
      bit_cnt   <= '0;
      init      <= 1'b1;
      pending   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Any number of forces during a frame collapse into one follow-up frame.
      if (state != IDLE && bus.force_req) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT_LO;
            shift_reg <= bus.led_in;
            last_sent <= bus.led_in;
            init      <= 1'b0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            busy_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= pick(bus.led_in);
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            state  <= SHIFT_HI;
            sclk_q <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              state   <= LATCH;
              latch_q <= 1'b1;
            end else begin
              state     <= SHIFT_LO;
              bit_cnt   <= bit_cnt + BW'(1);
              shift_reg <= shifted;
              sdata_q   <= pick(shifted);
            end
          end
        end
        LATCH: begin
          if (tick) begin
            state   <= IDLE;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sdata_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.latch = latch_q;

endmodule
